adc_scan_seq: RTL and testbench
===============================

ADC_SCAN_SEQ -- requirements
Module: adc_scan_seq

Interface
REQ-001 SHALL have parameter N_CH, 32, number of multiplexer channels (2..64).
REQ-002 SHALL have parameter DW, 8, sample/FIFO word width (>=8).
REQ-003 SHALL have parameter SETTLE, 500000, settle cycles per channel (>=1, elaboration error otherwise).
REQ-004 SHALL have parameter SCANS, 4, full passes over enabled channels per frame (>=1).
REQ-005 SHALL have parameter DEPTH, 4096, FIFO words (power of two).
REQ-006 SHALL have ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: start in 1 frame start pulse; abort in 1 cancel; continuous in 1 auto-restart mode.
REQ-008 SHALL have ports: ch_mask in N_CH channel enables; adc_data in DW converter result.
REQ-009 SHALL have ports: addr out clog2(N_CH) mux select; busy out 1 frame active; frame_done out 1 one-cycle pulse.
REQ-010 SHALL have ports: rd_en in 1; rd_data out DW; empty out 1; full out 1; level out clog2(DEPTH)+1 word count; state_dbg out 4 encoded state.

Function
REQ-011 SHALL implement states IDLE, SELECT, SETTLE, SAMPLE, TRAIL0, TRAIL1, DONE.
REQ-012 IDLE: start=1 and latched-to-be ch_mask!=0 and abort=0 -> SELECT; ch_mask latched, channel index and scan count cleared; start with ch_mask==0 ignored.
REQ-013 SELECT: disabled current channel -> advance index, stay SELECT (one cycle per skip); enabled -> addr<=index, SETTLE.
REQ-014 SETTLE SHALL last exactly SETTLE cycles, then SAMPLE.
REQ-015 SAMPLE: full=0 -> write adc_data to FIFO this cycle; full=1 -> hold in SAMPLE, no write, no data loss.
REQ-016 After write: last enabled channel of pass -> scan count+1; scan count reaching SCANS -> TRAIL0, else index wraps to 0 -> SELECT.
REQ-017 TRAIL0 SHALL write 8'h0D, TRAIL1 SHALL write 8'h0A, both zero-extended to DW, each stalling while full.
REQ-018 DONE SHALL pulse frame_done one cycle; continuous=1 -> SELECT with fresh counters and re-latched ch_mask; else IDLE.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE next cycle, no trailer, no frame_done, FIFO contents kept, addr<=0; abort beats start.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 FIFO read: rd_en with empty=0 pops; rd_data registered, valid cycle after rd_en; rd_en on empty ignored, rd_data holds.
REQ-022 Simultaneous read and write SHALL keep level unchanged; write when full blocked at source, never overflows; pointers wrap modulo DEPTH.
REQ-023 level, empty, full SHALL update the cycle after the causing edge; full = (level==DEPTH).
REQ-024 state_dbg SHALL encode IDLE..DONE as 0..6.

Reset
REQ-025 reset_n=0 SHALL force IDLE, addr=0, busy=0, frame_done=0, rd_data=0, level=0, empty=1, full=0, counters cleared, immediately and independent of clk.
REQ-026 Reset mid-frame SHALL discard FIFO contents; no trailer emitted.

Structure
REQ-027 State encoding, trailer constants 8'h0D/8'h0A and clog2 helper SHALL live in shared package adc_scan_pkg.
REQ-028 FIFO SHALL be sub-module scan_fifo (DW, DEPTH parameters, registered read, level output); sequencer stays in adc_scan_seq.

Verification (N_CH=4, DW=8, SETTLE=3, SCANS=2, DEPTH=16 unless stated)
REQ-029 ch_mask=4'b1011, adc_data=addr+8'h10, start pulse -> FIFO words 10,11,13,10,11,13,0D,0A; frame_done one pulse; each SETTLE 3 cycles.
REQ-030 DEPTH=4, rd_en=0, mask=4'b1111 -> stall in SAMPLE at full=1, level=4; reading one word releases exactly one write; all 10 words arrive in order.
REQ-031 abort asserted during second SETTLE -> IDLE next cycle, busy=0, level=1, no 0D/0A, frame_done stays 0.
REQ-032 continuous=1, mask=4'b0001 -> repeating 10,10,0D,0A frames, frame_done per frame; continuous dropped -> IDLE after current DONE.
REQ-033 start with ch_mask=0 -> stays IDLE, busy=0; rd_en on empty -> level=0, rd_data unchanged.
REQ-034 reset_n pulsed mid-SETTLE with level=3 -> all outputs at REQ-025 values before next clk edge.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types, constants and helpers for the ADC scan sequencer
//
// Contents:
//   scan_state_t  sequencer state encoding (IDLE..DONE = 0..6, also the state_dbg value)
//   TRAIL_CR      first frame trailer byte (carriage return)
//   TRAIL_LF      second frame trailer byte (line feed)
//   clog2()       ceiling log2 for sizing ports and counters
package adc_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SELECT = 4'd1,
    ST_SETTLE = 4'd2,
    ST_SAMPLE = 4'd3,
    ST_TRAIL0 = 4'd4,
    ST_TRAIL1 = 4'd5,
    ST_DONE   = 4'd6
  } scan_state_t;

  localparam logic [7:0] TRAIL_CR = 8'h0D;
  localparam logic [7:0] TRAIL_LF = 8'h0A;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/scan_fifo.sv
// rtl/scan_fifo.sv - sample FIFO with registered read data and word-count output
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wr_data push one word; ignored while full
//   rd_en         pop one word; ignored while empty
//   rd_data       popped word, valid the cycle after rd_en; holds otherwise
//   empty, full   registered-level flags
//   level         current word count (0..DEPTH)
module scan_fifo
  import adc_scan_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("scan_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          do_wr;
  logic          do_rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);
  assign level = level_q;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_scan_seq.sv
// rtl/adc_scan_seq.sv - multiplexed ADC scan sequencer feeding a sample FIFO
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             frame start pulse (ignored with an all-zero ch_mask)
//   abort             cancel the current frame, back to IDLE without trailer
//   continuous        restart a new frame straight after DONE
//   ch_mask           channel enables, latched at frame start
//   adc_data          converter result, sampled in SAMPLE
//   addr              multiplexer select
//   busy, frame_done  frame active, one-cycle end-of-frame pulse
//   rd_en, rd_data    FIFO pop and registered read data
//   empty, full, level FIFO status
//   state_dbg         encoded sequencer state
module adc_scan_seq
  import adc_scan_pkg::*;
#(
  parameter int N_CH   = 32,
  parameter int DW     = 8,
  parameter int SETTLE = 500000,
  parameter int SCANS  = 4,
  parameter int DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [DW-1:0]         adc_data,
  output logic [clog2(N_CH)-1:0] addr,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  rd_en,
  output logic [DW-1:0]         rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] level,
  output logic [3:0]            state_dbg
);

  localparam int AW = clog2(N_CH);
  localparam int CW = clog2(SETTLE) + 1;
  localparam int SW = clog2(SCANS) + 1;

  if (SETTLE < 1) begin : g_chk_settle
    $error("adc_scan_seq: SETTLE must be >= 1");
  end
  if (N_CH < 2 || N_CH > 64) begin : g_chk_nch
    $error("adc_scan_seq: N_CH must be 2..64");
  end
  if (DW < 8) begin : g_chk_dw
    $error("adc_scan_seq: DW must be >= 8");
  end
  if (SCANS < 1) begin : g_chk_scans
    $error("adc_scan_seq: SCANS must be >= 1");
  end

  scan_state_t    state_q, state_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [AW-1:0]  idx_q, idx_d, idx_next;
  logic [SW-1:0]  scan_q, scan_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           last_ch;
  logic           fifo_wr;
  logic [DW-1:0]  fifo_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      scan_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    scan_d     = scan_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    fifo_wr    = 1'b0;
    fifo_wdata = adc_data;

    // The current channel closes a pass when no higher channel is enabled.
    last_ch = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (mask_q[i] && (i > int'(idx_q))) last_ch = 1'b0;
    end
    idx_next = (idx_q == AW'(N_CH - 1)) ? '0 : idx_q + AW'(1);

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort && (|ch_mask)) begin
            state_d = ST_SELECT;
            mask_d  = ch_mask;
            idx_d   = '0;
            scan_d  = '0;
          end
        end
        ST_SELECT: begin
          if (mask_q[idx_q]) begin
            addr_d  = idx_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            idx_d = idx_next;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE - 1)) state_d = ST_SAMPLE;
          else                          cnt_d   = cnt_q + CW'(1);
        end
        ST_SAMPLE: begin
          if (!full) begin
            fifo_wr = 1'b1;
            if (!last_ch) begin
              idx_d   = idx_next;
              state_d = ST_SELECT;
            end else if (scan_q == SW'(SCANS - 1)) begin
              state_d = ST_TRAIL0;
            end else begin
              scan_d  = scan_q + SW'(1);
              idx_d   = '0;
              state_d = ST_SELECT;
            end
          end
        end
        ST_TRAIL0: begin
          fifo_wdata = DW'(TRAIL_CR);
          if (!full) begin
            fifo_wr = 1'b1;
            state_d = ST_TRAIL1;
          end
        end
        ST_TRAIL1: begin
          fifo_wdata = DW'(TRAIL_LF);
          if (!full) begin
            fifo_wr = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // An all-zero mask at restart would spin in SELECT forever.
          if (continuous && (|ch_mask)) begin
            state_d = ST_SELECT;
            mask_d  = ch_mask;
            idx_d   = '0;
            scan_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign state_dbg  = state_q;

  scan_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

endmodule

// File: tb/tb_adc_scan_seq.sv
// tb/tb_adc_scan_seq.sv - self-checking bench for adc_scan_seq
module tb_adc_scan_seq;

  logic       clk;
  logic       reset_n;
  logic       start, abort, continuous;
  logic [3:0] ch_mask;
  logic [7:0] adc_data;
  logic [1:0] addr;
  logic       busy, frame_done;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [4:0] level;
  logic [3:0] state_dbg;

  logic       start4, rd_en4;
  logic [7:0] adc_data4;
  logic [1:0] addr4;
  logic       busy4, frame_done4;
  logic [7:0] rd_data4;
  logic       empty4, full4;
  logic [2:0] level4;
  logic [3:0] state_dbg4;

  int n_pass, n_fail, n_total;
  int fd4_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];

  assign adc_data  = 8'h10 + {6'd0, addr};
  assign adc_data4 = 8'h10 + {6'd0, addr4};

  adc_scan_seq #(.N_CH(4), .DW(8), .SETTLE(3), .SCANS(2), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .continuous(continuous), .ch_mask(ch_mask), .adc_data(adc_data),
    .addr(addr), .busy(busy), .frame_done(frame_done), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .state_dbg(state_dbg)
  );

  adc_scan_seq #(.N_CH(4), .DW(8), .SETTLE(3), .SCANS(2), .DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort),
    .continuous(continuous), .ch_mask(ch_mask), .adc_data(adc_data4),
    .addr(addr4), .busy(busy4), .frame_done(frame_done4), .rd_en(rd_en4),
    .rd_data(rd_data4), .empty(empty4), .full(full4), .level(level4),
    .state_dbg(state_dbg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done4 === 1'b1) fd4_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (frame_done !== 1'b1 && k < 200);
    check(tag, frame_done, 1);
  endtask

  // Advance until the n-th entry into SETTLE; leaves the bench in its first cycle.
  task automatic wait_settle_entry(input int n, input string tag);
    int k, seen;
    logic [3:0] prev;
    k = 0; seen = 0; prev = state_dbg;
    while (seen < n && k < 300) begin
      tick();
      k++;
      if (state_dbg == 4'd2 && prev != 4'd2) seen++;
      prev = state_dbg;
    end
    check(tag, seen, n);
  endtask

  task automatic drain(input int n, input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check(tag, rd_data, exp_q.pop_front());
    end
    rd_en = 1'b0;
  endtask

  initial begin
    int k, got4, runs, bad_runs, run, pulses;
    logic pre_empty;
    n_pass = 0; n_fail = 0; n_total = 0; fd4_cnt = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    ch_mask = 4'b0; rd_en = 1'b0; start4 = 1'b0; rd_en4 = 1'b0;

    repeat (3) tick();
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    reset_n = 1'b1;
    tick();

    // Back-pressure on a 4-word FIFO
    ch_mask = 4'b1111;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 4; c++) exp4_q.push_back(8'h10 + 8'(c));
    exp4_q.push_back(8'h0D);
    exp4_q.push_back(8'h0A);
    start4 = 1'b1; tick(); start4 = 1'b0;
    k = 0;
    while (full4 !== 1'b1 && k < 200) begin tick(); k++; end
    check("bp_full", full4, 1);
    repeat (12) tick();
    check("bp_stall_state", state_dbg4, 3);
    check("bp_stall_level", level4, 4);
    check("bp_busy", busy4, 1);
    rd_en4 = 1'b1; tick(); rd_en4 = 1'b0;
    check("bp_first_word", rd_data4, exp4_q.pop_front());
    got4 = 1;
    repeat (10) tick();
    check("bp_one_release_level", level4, 4);
    check("bp_one_release_state", state_dbg4, 3);
    rd_en4 = 1'b1;
    k = 0;
    while (got4 < 10 && k < 300) begin
      pre_empty = empty4;
      tick();
      k++;
      if (!pre_empty) begin
        if (exp4_q.size() == 0) check("bp_sb_empty", 32'd1, 32'd0);
        else check("bp_word", rd_data4, exp4_q.pop_front());
        got4++;
      end
    end
    rd_en4 = 1'b0;
    check("bp_word_count", got4, 10);
    repeat (3) tick();
    check("bp_idle", state_dbg4, 0);
    check("bp_empty", empty4, 1);
    check("bp_frame_done_count", fd4_cnt, 1);

    // Start with empty mask; read on empty FIFO
    ch_mask = 4'b0000;
    pulse_start();
    tick();
    check("nomask_state", state_dbg, 0);
    check("nomask_busy", busy, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
    check("rd_empty_level", level, 0);
    check("rd_empty_data", rd_data, 0);
    check("rd_empty_flag", empty, 1);

    // Basic frame, mask 1011
    ch_mask = 4'b1011;
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h13);
    end
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    pulse_start();
    check("frame_busy", busy, 1);
    k = 0; runs = 0; bad_runs = 0; run = 0; pulses = 0;
    while (state_dbg != 4'd0 && k < 400) begin
      if (state_dbg == 4'd2) run++;
      else if (run != 0) begin
        if (run != 3) bad_runs++;
        runs++;
        run = 0;
      end
      if (frame_done === 1'b1) pulses++;
      tick();
      k++;
    end
    check("frame_settle_runs", runs, 6);
    check("frame_settle_len_bad", bad_runs, 0);
    check("frame_done_pulses", pulses, 1);
    check("frame_level", level, 8);
    drain(8, "frame_word");
    check("frame_drained", empty, 1);

    // Abort during the second SETTLE
    ch_mask = 4'b1011;
    exp_q.push_back(8'h10);
    pulse_start();
    wait_settle_entry(2, "abort_reach_settle2");
    check("abort_addr_before", addr, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_state", state_dbg, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", addr, 0);
    check("abort_level", level, 1);
    repeat (5) tick();
    check("abort_no_trailer", level, 1);
    check("abort_no_done", frame_done, 0);
    drain(1, "abort_word");
    check("abort_drained", empty, 1);

    // Continuous mode, mask 0001
    ch_mask = 4'b0001;
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(8'h10); exp_q.push_back(8'h10);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
    pulse_start();
    wait_pulse("cont_frame1");
    wait_pulse("cont_frame2");
    tick();
    continuous = 1'b0;
    check("cont_restarted", busy, 1);
    wait_pulse("cont_frame3");
    tick();
    check("cont_stop_state", state_dbg, 0);
    check("cont_stop_level", level, 12);
    repeat (4) tick();
    check("cont_no_more_done", frame_done, 0);
    drain(12, "cont_word");
    check("cont_drained", empty, 1);

    // Asynchronous reset mid-SETTLE
    ch_mask = 4'b1111;
    pulse_start();
    wait_settle_entry(4, "rst_reach_settle4");
    tick();
    check("rst_mid_level_before", level, 3);
    check("rst_mid_state_before", state_dbg, 2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", state_dbg, 0);
    check("arst_busy", busy, 0);
    check("arst_done", frame_done, 0);
    check("arst_addr", addr, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    exp_q.delete();
    #1 reset_n = 1'b1;
    repeat (10) tick();
    check("arst_stays_idle", state_dbg, 0);
    check("arst_no_trailer", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
